// File: rtl/dnn_mem_pkg.sv
// Shared types and defaults for the DNN SDRAM arbiter slice.
package dnn_mem_pkg;

    localparam int unsigned AW_DEF = 32;
    localparam int unsigned DW_DEF = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Tag width for n requesters; never narrower than one bit.
    function automatic int unsigned tag_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dnn_tag_fifo.sv
// In-order tag FIFO recording which requester owns each outstanding read.
module dnn_tag_fifo #(
    parameter  int unsigned W     = 1,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Storage needs no reset: validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/dnn_mem_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM master among NREQ requesters,
// with in-order read-response routing via a tag FIFO.
module dnn_mem_arbiter
    import dnn_mem_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned MAX_OUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ*AW-1:0]   req_address,
    input  logic [NREQ-1:0]      req_read,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*DW-1:0]   req_writedata,
    output logic [NREQ-1:0]      req_waitrequest,
    output logic [DW-1:0]        req_readdata,
    output logic [NREQ-1:0]      req_readdatavalid,
    input  logic                 master_waitrequest,
    output logic [AW-1:0]        master_address,
    output logic                 master_read,
    output logic                 master_write,
    output logic [DW-1:0]        master_writedata,
    input  logic [DW-1:0]        master_readdata,
    input  logic                 master_readdatavalid,
    output logic                 rsp_orphan
);

    localparam int unsigned TW = tag_width(NREQ);
    localparam int unsigned SW = TW + 1;
    localparam int unsigned CW = $clog2(MAX_OUT) + 1;

    arb_state_t      state_q, state_d;
    logic [TW-1:0]   gnt_q, gnt_d;
    logic [TW-1:0]   rr_q, rr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            mrd_q, mrd_d;
    logic            mwr_q, mwr_d;
    logic [NREQ-1:0] rdv_q, rdv_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            orphan_q, orphan_d;

    logic [AW-1:0]   req_addr_a  [NREQ];
    logic [DW-1:0]   req_wdata_a [NREQ];
    logic [NREQ-1:0] eligible_c;
    logic            pick_valid_c;
    logic [TW-1:0]   pick_idx_c;
    logic [TW-1:0]   cand_c;
    logic            accept_c;

    logic            fifo_push;
    logic            fifo_pop;
    logic [TW-1:0]   fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   tag_count_unused;

    // (base + k) mod NREQ without a divider.
    function automatic logic [TW-1:0] wrap_add(input logic [TW-1:0] base, input int unsigned k);
        logic [SW-1:0] s;
        s = {1'b0, base} + SW'(k);
        if (s >= SW'(NREQ)) begin
            s = s - SW'(NREQ);
        end
        return s[TW-1:0];
    endfunction

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign req_addr_a[g]  = req_address[g*AW +: AW];
        assign req_wdata_a[g] = req_writedata[g*DW +: DW];
    end

    // A read+write request is treated as a read, so it must respect the FIFO limit.
    always_comb begin
        eligible_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            eligible_c[i] = req_read[i] ? !fifo_full : req_write[i];
        end
    end

    // First eligible requester at or after the round-robin pointer.
    always_comb begin
        pick_valid_c = 1'b0;
        pick_idx_c   = '0;
        cand_c       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand_c = wrap_add(rr_q, k);
            if (!pick_valid_c && eligible_c[cand_c]) begin
                pick_valid_c = 1'b1;
                pick_idx_c   = cand_c;
            end
        end
    end

    assign accept_c  = (state_q == GRANT) && !master_waitrequest;
    assign fifo_push = accept_c && mrd_q;
    assign fifo_pop  = master_readdatavalid && !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mrd_q    <= 1'b0;
            mwr_q    <= 1'b0;
            rdv_q    <= '0;
            rdata_q  <= '0;
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_q     <= rr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mrd_q    <= mrd_d;
            mwr_q    <= mwr_d;
            rdv_q    <= rdv_d;
            rdata_q  <= rdata_d;
            orphan_q <= orphan_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_d     = rr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mrd_d    = mrd_q;
        mwr_d    = mwr_q;
        rdv_d    = '0;
        rdata_d  = rdata_q;
        orphan_d = orphan_q;

        case (state_q)
            IDLE: begin
                if (pick_valid_c) begin
                    state_d = GRANT;
                    gnt_d   = pick_idx_c;
                    addr_d  = req_addr_a[pick_idx_c];
                    wdata_d = req_wdata_a[pick_idx_c];
                    mrd_d   = req_read[pick_idx_c];
                    mwr_d   = req_write[pick_idx_c] && !req_read[pick_idx_c];
                end
            end
            GRANT: begin
                if (!master_waitrequest) begin
                    state_d = IDLE;
                    rr_d    = wrap_add(gnt_q, 1);
                    mrd_d   = 1'b0;
                    mwr_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Response routing: data with no owner is dropped and flagged.
        if (master_readdatavalid) begin
            if (fifo_empty) begin
                orphan_d = 1'b1;
            end else begin
                rdv_d[fifo_head] = 1'b1;
                rdata_d          = master_readdata;
            end
        end
    end

    always_comb begin
        req_waitrequest = '1;
        if (accept_c) begin
            req_waitrequest[gnt_q] = 1'b0;
        end
    end

    assign master_address    = addr_q;
    assign master_writedata  = wdata_q;
    assign master_read       = mrd_q;
    assign master_write      = mwr_q;
    assign req_readdatavalid = rdv_q;
    assign req_readdata      = rdata_q;
    assign rsp_orphan        = orphan_q;

    dnn_tag_fifo #(
        .W     (TW),
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (gnt_q),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (tag_count_unused)
    );

endmodule
